// File: rtl/bus_resp_pkg.sv
// Shared types and defaults for the bus_ack_responder block.
package bus_resp_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/bus_resp_fifo.sv
// Request queue for bus_ack_responder: DEPTH x DATA_W synchronous FIFO.
// A push into a full queue is still accepted when a pop happens in the same cycle.
module bus_resp_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign empty     = (count_r == CW'(0));
    assign full      = (count_r == CW'(DEPTH));
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign rd_data   = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer and occupancy update; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
        end
    end

    // Storage array; entries are never read before being written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/bus_ack_responder.sv
// Responder side of the bus_req/bus_ack handshake: queues request pulses and
// returns one registered single-cycle ack per request, in order, after ACK_DELAY cycles.
module bus_ack_responder
    import bus_resp_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = 4,
    parameter int ACK_DELAY = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bus_req,
    input  logic [DATA_W-1:0]          bus_data,
    output logic                       bus_ack,
    output logic [DATA_W-1:0]          ack_data,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       busy,
    output logic                       overflow
);
    localparam int CNT_W = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              bus_ack_r;
    logic [DATA_W-1:0] ack_data_r;
    logic              overflow_r;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [DATA_W-1:0] fifo_head_s;
    logic [CW-1:0]     fifo_count_s;

    // The head leaves the queue on the edge that ends the ACK cycle.
    assign pop_s = (state_r == ST_ACK);

    bus_resp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (bus_req),
        .wr_data (bus_data),
        .pop     (pop_s),
        .rd_data (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Next-state and service-delay counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = CNT_W'(ACK_DELAY - 1);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == CNT_W'(0)) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_ACK: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_W'(0);
            end
        endcase
    end

    // State, registered ack outputs and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_W'(0);
            bus_ack_r  <= 1'b0;
            ack_data_r <= DATA_W'(0);
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            bus_ack_r  <= (state_nxt_s == ST_ACK);
            ack_data_r <= (state_nxt_s == ST_ACK) ? fifo_head_s : DATA_W'(0);
            if (bus_req && fifo_full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign bus_ack  = bus_ack_r;
    assign ack_data = ack_data_r;
    assign overflow = overflow_r;
    assign pending  = fifo_count_s;
    assign busy     = (state_r != ST_IDLE) || (fifo_count_s != CW'(0));

endmodule

// File: tb/tb_bus_ack_responder.sv
// Self-checking bench: three responders (ACK_DELAY 1, 3, 8) share one stimulus
// stream and are compared every cycle against an event-scheduled queue model.
module tb_bus_ack_responder;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        bus_req  = 1'b0;
    logic [31:0] bus_data = 32'd0;

    logic        ack_o  [3];
    logic [31:0] ackd_o [3];
    logic [2:0]  pend_o [3];
    logic        busy_o [3];
    logic        ovf_o  [3];

    always #5 clk = ~clk;

    bus_ack_responder #(.DATA_W(DW), .DEPTH(DEPTH), .ACK_DELAY(1)) dut_d1 (
        .clk(clk), .reset(reset), .bus_req(bus_req), .bus_data(bus_data),
        .bus_ack(ack_o[0]), .ack_data(ackd_o[0]), .pending(pend_o[0]),
        .busy(busy_o[0]), .overflow(ovf_o[0]));
    bus_ack_responder #(.DATA_W(DW), .DEPTH(DEPTH), .ACK_DELAY(3)) dut_d3 (
        .clk(clk), .reset(reset), .bus_req(bus_req), .bus_data(bus_data),
        .bus_ack(ack_o[1]), .ack_data(ackd_o[1]), .pending(pend_o[1]),
        .busy(busy_o[1]), .overflow(ovf_o[1]));
    bus_ack_responder #(.DATA_W(DW), .DEPTH(DEPTH), .ACK_DELAY(8)) dut_d8 (
        .clk(clk), .reset(reset), .bus_req(bus_req), .bus_data(bus_data),
        .bus_ack(ack_o[2]), .ack_data(ackd_o[2]), .pending(pend_o[2]),
        .busy(busy_o[2]), .overflow(ovf_o[2]));

    // Reference model: a queue per instance plus the cycle its head is due to be acked.
    int          dly    [3] = '{1, 3, 8};
    logic [31:0] mq     [3][$];
    int          ack_at [3] = '{-1, -1, -1};
    bit          movf   [3] = '{1'b0, 1'b0, 1'b0};
    bit          model_ok   = 1'b0;
    int          t          = 0;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        req;
        logic [31:0] data;
        logic        ack;
        logic [31:0] ad;
        logic [2:0]  pend;
        logic        busy;
        logic        ovf;
    } vec_t;
    vec_t tbl[$];

    logic [31:0] got[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, t);
        end
    endtask

    task automatic model_check();
        for (int i = 0; i < 3; i++) begin
            bit          ea;
            logic [31:0] ed;
            ea = (ack_at[i] == t) && (mq[i].size() > 0);
            ed = ea ? mq[i][0] : 32'd0;
            chk($sformatf("model_ack[%0d]", i), 32'(ack_o[i]), 32'(ea));
            chk($sformatf("model_data[%0d]", i), ackd_o[i], ed);
            chk($sformatf("model_pending[%0d]", i), 32'(pend_o[i]), 32'(mq[i].size()));
            chk($sformatf("model_busy[%0d]", i), 32'(busy_o[i]),
                32'((ack_at[i] >= 0) || (mq[i].size() > 0)));
            chk($sformatf("model_ovf[%0d]", i), 32'(ovf_o[i]), 32'(movf[i]));
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                mq[i].delete();
                ack_at[i] = -1;
                movf[i]   = 1'b0;
            end else begin
                bit pop;
                int sz;
                pop = (ack_at[i] == t);
                sz  = mq[i].size();
                if (pop) begin
                    void'(mq[i].pop_front());
                    ack_at[i] = -1;
                end else if (ack_at[i] < 0 && sz > 0) begin
                    ack_at[i] = t + 1 + dly[i];
                end
                if (bus_req) begin
                    if (sz < DEPTH || pop) mq[i].push_back(bus_data);
                    else movf[i] = 1'b1;
                end
            end
        end
        if (reset) model_ok = 1'b1;
        t++;
    endtask

    task automatic settle();
        @(negedge clk);
        if (model_ok) model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic r, input logic [31:0] d);
        bus_req  = r;
        bus_data = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'd0);
        settle();
        advance();
        reset = 1'b0;
    endtask

    initial begin
        // single request, then three spaced requests, as seen by the ACK_DELAY=1 instance
        tbl.push_back(vec_t'{1'b1, 32'hfeed, 1'b0, 32'h0,    3'd0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h0,    1'b0, 32'h0,    3'd1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h0,    1'b0, 32'h0,    3'd1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h0,    1'b1, 32'hfeed, 3'd1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h0,    1'b0, 32'h0,    3'd0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h0,    1'b0, 32'h0,    3'd0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 32'd1,    1'b0, 32'h0,    3'd0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h0,    1'b0, 32'h0,    3'd1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b1, 32'd2,    1'b0, 32'h0,    3'd1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h0,    1'b1, 32'd1,    3'd2, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b1, 32'd3,    1'b0, 32'h0,    3'd1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h0,    1'b0, 32'h0,    3'd2, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h0,    1'b1, 32'd2,    3'd2, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h0,    1'b0, 32'h0,    3'd1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h0,    1'b0, 32'h0,    3'd1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h0,    1'b1, 32'd3,    3'd1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h0,    1'b0, 32'h0,    3'd0, 1'b0, 1'b0});

        do_reset();
        settle();
        for (int i = 0; i < 3; i++) begin
            chk("rst_ack", 32'(ack_o[i]), 32'd0);
            chk("rst_data", ackd_o[i], 32'd0);
            chk("rst_pending", 32'(pend_o[i]), 32'd0);
            chk("rst_busy", 32'(busy_o[i]), 32'd0);
            chk("rst_ovf", 32'(ovf_o[i]), 32'd0);
        end
        advance();

        foreach (tbl[k]) begin
            drive(tbl[k].req, tbl[k].data);
            settle();
            chk($sformatf("tbl%0d_ack", k), 32'(ack_o[0]), 32'(tbl[k].ack));
            chk($sformatf("tbl%0d_data", k), ackd_o[0], tbl[k].ad);
            chk($sformatf("tbl%0d_pending", k), 32'(pend_o[0]), 32'(tbl[k].pend));
            chk($sformatf("tbl%0d_busy", k), 32'(busy_o[0]), 32'(tbl[k].busy));
            chk($sformatf("tbl%0d_ovf", k), 32'(ovf_o[0]), 32'(tbl[k].ovf));
            advance();
        end

        // ACK_DELAY=3: single request acked in cycle 5 only
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(c == 0, 32'h3333);
            settle();
            chk($sformatf("dly3_ack_c%0d", c), 32'(ack_o[1]), 32'(c == 5));
            if (c == 5) chk("dly3_data", ackd_o[1], 32'h3333);
            advance();
        end

        // overflow: six back-to-back requests into a 4-deep queue, ACK_DELAY=8
        do_reset();
        got.delete();
        for (int c = 0; c < 50; c++) begin
            drive(c < 6, 32'(10 + c));
            settle();
            if (c <= 5) chk($sformatf("ovf_pending_c%0d", c), 32'(pend_o[2]), 32'((c < 4) ? c : 4));
            if (c <= 9) chk($sformatf("ovf_flag_c%0d", c), 32'(ovf_o[2]), 32'(c >= 5));
            if (ack_o[2]) got.push_back(ackd_o[2]);
            advance();
        end
        chk("ovf_ack_count", 32'(got.size()), 32'd4);
        for (int j = 0; j < 4; j++) begin
            if (j < got.size()) chk($sformatf("ovf_ack_data%0d", j), got[j], 32'(10 + j));
        end

        // push arriving exactly in the ACK cycle of a full queue
        do_reset();
        for (int c = 0; c < 14; c++) begin
            drive((c < 4) || (c == 10), 32'(20 + c));
            settle();
            if (c == 10) begin
                chk("fullack_ack", 32'(ack_o[2]), 32'd1);
                chk("fullack_data", ackd_o[2], 32'd20);
                chk("fullack_pending", 32'(pend_o[2]), 32'd4);
            end
            if (c == 11) begin
                chk("fullack_pending_after", 32'(pend_o[2]), 32'd4);
                chk("fullack_ovf", 32'(ovf_o[2]), 32'd0);
            end
            advance();
        end

        // reset during WAIT flushes the queue; a later request is served normally
        do_reset();
        for (int c = 0; c < 11; c++) begin
            reset = (c == 2);
            drive((c < 3) || (c == 5), 32'(32'h50 + c));
            settle();
            if (c == 3) begin
                chk("midrst_pending", 32'(pend_o[0]), 32'd0);
                chk("midrst_busy", 32'(busy_o[0]), 32'd0);
                chk("midrst_ovf", 32'(ovf_o[0]), 32'd0);
            end
            if (c >= 3) chk($sformatf("midrst_ack_c%0d", c), 32'(ack_o[0]), 32'(c == 8));
            if (c == 8) chk("midrst_data", ackd_o[0], 32'h55);
            advance();
        end
        reset = 1'b0;

        // randomized traffic with varying request density and rare resets
        for (int blk = 0; blk < 20; blk++) begin
            int dens;
            dens = int'($urandom_range(1, 9));
            for (int c = 0; c < 100; c++) begin
                reset = ($urandom_range(0, 299) == 0);
                drive(int'($urandom_range(0, 9)) < dens, $urandom);
                settle();
                advance();
            end
        end
        reset = 1'b0;
        drive(1'b0, 32'd0);
        for (int c = 0; c < 60; c++) begin
            settle();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
